win_feed_gen: RTL and testbench
===============================

Name: win_feed_gen

Overview:
- Producer side of the arithmetic core's window interface.
- Buffers one input feature map arriving as a raster pixel stream, then emits packed 3x3 windows with a contiguous enable strobe. Each window is 9 bytes, 72 bits at defaults.
- Emission order is either plain raster or 2x2-pool-group order, so the core's max-pool stage receives its four members on consecutive cycles.
- Sits between the input-feature SRAM/DMA and arithmetic_core_mod `in`/`en`.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 10, stored frame width in pixels, border included.
- IMG_H, 10, stored frame height in pixels, border included.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_in  in  DATA_W  pixel data, raster order, row 0 first.
- pix_valid  in  1  pixel qualifier.
- pix_ready  out  1  frame buffer accepting pixels.
- pool_order  in  1  1 = 2x2-group order, 0 = raster order. Sampled on the LOAD->EMIT transition.
- win  out  9*DATA_W  window {p00,p01,p02,p10,p11,p12,p20,p21,p22}; p00 in MSBs, same byte order as the core's weight vector.
- win_en  out  1  window valid, drives core `en`.
- frame_done  out  1  one-cycle pulse after the last window.
- busy  out  1  high in EMIT and DONE.

Behaviour:
- Derived sizes: OUT_W = IMG_W-2, OUT_H = IMG_H-2, NWIN = OUT_W*OUT_H (64 at defaults).
- Reset (async) values:
  - state = LOAD; all counters = 0.
  - pix_ready = 0, win = 0, win_en = 0, frame_done = 0, busy = 0.
  - Frame buffer contents are undefined.
- pix_ready is a registered output. It becomes 1 on the first clk edge after reset deasserts.
- LOAD state:
  - A pixel is accepted when pix_valid && pix_ready. It is written to address wr_cnt, and wr_cnt increments.
  - When the pixel at address IMG_W*IMG_H-1 is accepted: pix_ready drops on the same edge, pool_order is latched, and the state moves to EMIT.
- EMIT state:
  - One window per cycle, no gaps, and no back-pressure. The core has no stall input.
  - First win_en = 1 on the cycle after the last pixel is accepted. Window k is presented on cycle k+1 after that acceptance.
  - Output coordinate (r,c) takes pixels rows r..r+2 and columns c..c+2. win and win_en are registered.
  - Raster order: r outer, c inner.
  - Pool order: groups (gr,gc) in raster over OUT_H/2 x OUT_W/2. Within each group the sequence is (2gr,2gc), (2gr,2gc+1), (2gr+1,2gc), (2gr+1,2gc+1).
  - After window NWIN-1, the state moves to DONE.
- DONE state:
  - win_en = 0 and frame_done = 1 for exactly one cycle. win holds the last window.
  - The next state is LOAD with pix_ready = 1. A new frame may start immediately.
- Pixels offered while pix_ready = 0 are ignored, not stored.
- pool_order = 1 with an odd OUT_W or OUT_H is illegal; an assertion flags it in simulation.
- Reset asserted mid-LOAD or mid-EMIT aborts immediately. All outputs return to their reset values, and any partial frame is discarded.

Optional Feature:
- Macro WIN_FEED_ZERO_PAD_EN.
- Defined:
  - The stream carries only interior pixels, (IMG_W-2)*(IMG_H-2) per frame, i.e. 64 at defaults. Only those pixels are stored.
  - Window reads at row 0, row IMG_H-1, column 0 or column IMG_W-1 return 0 (same-size convolution).
  - The LOAD exit condition uses the interior count.
- Undefined: the full padded frame of IMG_W*IMG_H pixels is streamed and stored.
- Window count and emission order are identical in both builds.

Decomposition:
- Package win_feed_pkg holds:
  - KSIZE = 3 and WIN_BYTES = 9.
  - State enum {LOAD, EMIT, DONE}.
  - A function packing 9 bytes into a window vector.
- Sub-module win_feed_addr_gen:
  - Holds the group/sub-position counters or the raster counters.
  - Outputs (r,c), first and last flags.
- The top level holds the frame buffer register array, a 9-tap combinational read, and the FSM.

Test Plan:
1. Frame of pix_in = address (0x00..0x63), pool_order = 1 -> windows 0..3 are:
   - 00,01,02,0A,0B,0C,14,15,16
   - 01,02,03,0B,0C,0D,15,16,17
   - 0A,0B,0C,14,15,16,1E,1F,20
   - 0B,0C,0D,15,16,17,1F,20,21
   Window 4 starts 02,03,04. Exactly 64 consecutive win_en, then one frame_done cycle.
2. Same frame with pool_order = 0 -> window 1 is (0,1) and window 8 is (1,0), starting 0A,0B,0C. The last window (7,7) is 4D,4E,4F,57,58,59,61,62,63.
3. Random pix_valid gaps (about 50%) -> the stored frame is unaffected and the window sequence is identical to scenario 1. Pixels offered during EMIT are ignored, and the next frame loads correctly.
4. Assert reset at EMIT window 20 -> win_en = 0 and win = 0 immediately, with no frame_done. pix_ready = 1 one cycle after release, and a full new frame reproduces scenario 1.
5. Back-to-back frames driven into arithmetic_core_mod with bias 0 and ReLU + max-pool enabled -> 16 outputs per frame match the golden output file exactly, with out_en high at each check.
6. With WIN_FEED_ZERO_PAD_EN and 64 interior pixels = 1 -> window 0 = 00,00,00,00,01,01,00,01,01, and window (3,3) is all ones.

Source files
------------

// File: rtl/win_feed_pkg.sv
// rtl/win_feed_pkg.sv - shared constants, FSM encoding and window packing helper for win_feed_gen
package win_feed_pkg;

  localparam int KSIZE      = 3;
  localparam int WIN_BYTES  = 9;
  localparam int MAX_DATA_W = 32;
  localparam int MAX_WIN_W  = WIN_BYTES * MAX_DATA_W;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shifts one tap in at the bottom; after nine calls p00 sits in the top lane.
  function automatic logic [MAX_WIN_W-1:0] win_pack_tap(input logic [MAX_WIN_W-1:0] acc,
                                                        input logic [MAX_DATA_W-1:0] tap,
                                                        input int width);
    return (acc << width) | MAX_WIN_W'(tap);
  endfunction

endpackage

// File: rtl/win_feed_addr_gen.sv
// rtl/win_feed_addr_gen.sv - window coordinate sequencer, raster or 2x2-pool-group order
module win_feed_addr_gen
  import win_feed_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int OUT_H = 8,
  parameter int RW    = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_i,
  input  logic          pool_i,
  output logic [RW-1:0] r_o,
  output logic [CW-1:0] c_o,
  output logic          first_o,
  output logic          last_o
);

  // In pool order row/col count 2x2 groups and sub selects the member.
  logic [RW-1:0] row_q, row_d, row_lim;
  logic [CW-1:0] col_q, col_d, col_lim;
  logic [1:0]    sub_q, sub_d;

  always_comb begin
    row_lim = pool_i ? RW'(OUT_H / 2 - 1) : RW'(OUT_H - 1);
    col_lim = pool_i ? CW'(OUT_W / 2 - 1) : CW'(OUT_W - 1);
    row_d   = row_q;
    col_d   = col_q;
    sub_d   = sub_q;
    if (step_i) begin
      if (pool_i && sub_q != 2'd3) begin
        sub_d = sub_q + 2'd1;
      end else begin
        sub_d = 2'd0;
        if (col_q == col_lim) begin
          col_d = '0;
          row_d = (row_q == row_lim) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      sub_q <= 2'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      sub_q <= sub_d;
    end
  end

  always_comb begin
    r_o     = pool_i ? ((row_q << 1) | RW'(sub_q[1])) : row_q;
    c_o     = pool_i ? ((col_q << 1) | CW'(sub_q[0])) : col_q;
    first_o = (row_q == '0) && (col_q == '0) && (sub_q == 2'd0);
    last_o  = (row_q == row_lim) && (col_q == col_lim) && (!pool_i || sub_q == 2'd3);
  end

endmodule

// File: rtl/win_feed_gen.sv
// rtl/win_feed_gen.sv - frame buffer and 3x3 window emitter; WIN_FEED_ZERO_PAD_EN streams interior pixels only and reads borders as 0
module win_feed_gen
  import win_feed_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic                          pool_order,
  output logic [WIN_BYTES*DATA_W-1:0]   win,
  output logic                          win_en,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
`ifdef WIN_FEED_ZERO_PAD_EN
  localparam int NSTORE = OUT_W * OUT_H;
`else
  localparam int NSTORE = IMG_W * IMG_H;
`endif
  localparam int AW = $clog2(NSTORE);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int WW = WIN_BYTES * DATA_W;

  state_e            state_q, state_d;
  logic              pix_ready_q, pool_q, tail_q, win_en_q;
  logic [AW-1:0]     wr_cnt_q;
  logic [WW-1:0]     win_q, win_d;
  logic [DATA_W-1:0] fb_q [NSTORE];
  logic              accept, load_last, fire, pool_sel, win_first, win_last;
  logic [RW-1:0]     win_r;
  logic [CW-1:0]     win_c;

  // Window 0 is registered on the same edge that accepts the last pixel.
  assign accept    = (state_q == LOAD) && pix_valid && pix_ready_q;
  assign load_last = accept && (wr_cnt_q == AW'(NSTORE - 1));
  assign fire      = load_last || ((state_q == EMIT) && !tail_q);
  assign pool_sel  = (state_q == LOAD) ? pool_order : pool_q;

  win_feed_addr_gen #(
    .OUT_W(OUT_W),
    .OUT_H(OUT_H),
    .RW   (RW),
    .CW   (CW)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .step_i (fire),
    .pool_i (pool_sel),
    .r_o    (win_r),
    .c_o    (win_c),
    .first_o(win_first),
    .last_o (win_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_last) state_d = EMIT;
      EMIT:    if (tail_q) state_d = DONE;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    busy       = (state_q != LOAD);
    frame_done = (state_q == DONE);
    pix_ready  = pix_ready_q;
    win        = win_q;
    win_en     = win_en_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_ready_q <= 1'b0;
      wr_cnt_q    <= '0;
      pool_q      <= 1'b0;
      tail_q      <= 1'b0;
      win_en_q    <= 1'b0;
      win_q       <= '0;
    end else begin
      pix_ready_q <= (state_d == LOAD);
      if (accept) wr_cnt_q <= load_last ? '0 : wr_cnt_q + 1'b1;
      if (load_last) pool_q <= pool_order;
      tail_q   <= fire && win_last;
      win_en_q <= fire;
      if (fire) win_q <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fb_q[wr_cnt_q] <= pix_in;
  end

  always_comb begin : taps
    int                       y, x, a;
    logic                     pad;
    logic [DATA_W-1:0]        px;
    logic [MAX_WIN_W-1:0]     acc;
    y   = 0;
    x   = 0;
    a   = 0;
    pad = 1'b0;
    px  = '0;
    acc = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      y = int'(win_r) + k / KSIZE;
      x = int'(win_c) + k % KSIZE;
`ifdef WIN_FEED_ZERO_PAD_EN
      pad = (y == 0) || (y == IMG_H - 1) || (x == 0) || (x == IMG_W - 1);
      a   = pad ? 0 : (y - 1) * OUT_W + (x - 1);
`else
      pad = 1'b0;
      a   = y * IMG_W + x;
`endif
      px = fb_q[AW'(a)];
      // Forward the pixel being written this edge; tiny frames can need it in window 0.
      if (accept && (AW'(a) == wr_cnt_q)) px = pix_in;
      if (pad) px = '0;
      acc = win_pack_tap(acc, MAX_DATA_W'(px), DATA_W);
    end
    win_d = WW'(acc);
  end

  // Pool order only forms complete 2x2 groups when both output dimensions are even.
  assert property (@(posedge clk) disable iff (reset)
    (load_last && pool_order) |-> ((OUT_W % 2 == 0) && (OUT_H % 2 == 0)));
  assert property (@(posedge clk) disable iff (reset) load_last |-> win_first);

endmodule

// File: tb/tb_win_feed_gen.sv
// tb/tb_win_feed_gen.sv - scoreboard and vector-table bench for win_feed_gen
module tb_win_feed_gen;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 10;
  localparam int IMG_H  = 10;
  localparam int OUT_W  = IMG_W - 2;
  localparam int OUT_H  = IMG_H - 2;
  localparam int NWIN   = OUT_W * OUT_H;
`ifdef WIN_FEED_ZERO_PAD_EN
  localparam int NSTORE = OUT_W * OUT_H;
`else
  localparam int NSTORE = IMG_W * IMG_H;
`endif
  localparam int WW = 9 * DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] pix_in = '0;
  logic              pix_valid = 1'b0;
  logic              pool_order = 1'b0;
  logic              pix_ready, win_en, frame_done, busy;
  logic [WW-1:0]     win;

  win_feed_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pool_order(pool_order),
    .win       (win),
    .win_en    (win_en),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pat;
    logic        pool;
    int          k;
    logic [WW-1:0] exp;
  } vec_t;

  vec_t              vecs [8];
  logic [DATA_W-1:0] frame_m [NSTORE];
  logic [WW-1:0]     exp_q [$];
  logic [WW-1:0]     got [NWIN];
  logic [WW-1:0]     last_exp;
  int                n_cmp = 0, n_err = 0, n_got = 0, run = 0, n_done = 0;
  logic              prev_en = 1'b0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] px(input int y, input int x);
`ifdef WIN_FEED_ZERO_PAD_EN
    if (y == 0 || x == 0 || y == IMG_H - 1 || x == IMG_W - 1) return '0;
    return frame_m[(y - 1) * OUT_W + (x - 1)];
`else
    return frame_m[y * IMG_W + x];
`endif
  endfunction

  function automatic logic [WW-1:0] model_win(input int r, input int c);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < 9; i++) w = (w << DATA_W) | WW'(px(r + i / 3, c + i % 3));
    return w;
  endfunction

  task automatic push_expected(input logic pool);
    int r, c, g, s;
    exp_q.delete();
    n_got = 0;
    for (int i = 0; i < NWIN; i++) got[i] = '0;
    for (int k = 0; k < NWIN; k++) begin
      if (pool) begin
        g = k / 4; s = k % 4;
        r = 2 * (g / (OUT_W / 2)) + s / 2;
        c = 2 * (g % (OUT_W / 2)) + s % 2;
      end else begin
        r = k / OUT_W; c = k % OUT_W;
      end
      last_exp = model_win(r, c);
      exp_q.push_back(last_exp);
    end
  endtask

  task automatic tick();
    logic [WW-1:0] e;
    @(posedge clk);
    #1;
    if (win_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL win_unexpected: got %h with empty scoreboard", win);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("win_%0d", n_got), win, e);
      end
      if (n_got < NWIN) got[n_got] = win;
      n_got++;
      run++;
    end
    if (frame_done || (prev_en && !win_en)) begin
      check("done_on_fall", WW'(frame_done), WW'(prev_en && !win_en));
      check("run_len", WW'(run), WW'(NWIN));
      n_done++;
    end
    if (!win_en) run = 0;
    prev_en = win_en;
  endtask

  task automatic load_frame(input int pat, input logic pool, input int gap);
    int idx = 0, guard = 0;
    bit v, acc;
    for (int i = 0; i < NSTORE; i++)
      frame_m[i] = (pat == 0) ? DATA_W'(i) : (pat == 2) ? DATA_W'(1) : DATA_W'($urandom);
    push_expected(pool);
    pool_order = pool;
    while (idx < NSTORE && guard < 20 * NSTORE) begin
      v = ($urandom_range(99) >= gap);
      pix_valid = v;
      pix_in = v ? frame_m[idx] : DATA_W'($urandom);
      acc = v && pix_ready;
      tick();
      guard++;
      if (acc) idx++;
    end
    pix_valid = 1'b0;
    check("load_complete", WW'(idx), WW'(NSTORE));
    check("first_win_en", WW'(win_en), WW'(1));
    check("ready_drop", WW'(pix_ready), WW'(0));
    check("busy_emit", WW'(busy), WW'(1));
  endtask

  task automatic drain(input bit noise);
    int guard = 0;
    int d0 = n_done;
    while (n_done == d0 && guard < 4 * NWIN) begin
      pix_valid = noise;
      pix_in = DATA_W'($urandom);
      pool_order = 1'($urandom_range(1));
      tick();
      guard++;
    end
    pix_valid = 1'b0;
    check("drain_done", WW'(n_done - d0), WW'(1));
    check("sb_empty", WW'(exp_q.size()), WW'(0));
    check("win_hold", win, last_exp);
    check("busy_done", WW'(busy), WW'(1));
    tick();
    check("ready_reload", WW'(pix_ready), WW'(1));
    check("busy_idle", WW'(busy), WW'(0));
  endtask

  task automatic table_check(input int pat, input logic pool);
    for (int i = 0; i < 8; i++)
      if (vecs[i].pat == pat && vecs[i].pool == pool)
        check($sformatf("vec%0d_k%0d", i, vecs[i].k), got[vecs[i].k], vecs[i].exp);
  endtask

  initial begin
    int g;
`ifdef WIN_FEED_ZERO_PAD_EN
    vecs[0] = '{pat: 2, pool: 1'b0, k: 0,  exp: 72'h000000_000101_000101};
    vecs[1] = '{pat: 2, pool: 1'b0, k: 27, exp: 72'h010101_010101_010101};
    for (int i = 2; i < 8; i++) vecs[i] = '{pat: -1, pool: 1'b0, k: 0, exp: '0};
`else
    vecs[0] = '{pat: 0, pool: 1'b1, k: 0,  exp: 72'h000102_0a0b0c_141516};
    vecs[1] = '{pat: 0, pool: 1'b1, k: 1,  exp: 72'h010203_0b0c0d_151617};
    vecs[2] = '{pat: 0, pool: 1'b1, k: 2,  exp: 72'h0a0b0c_141516_1e1f20};
    vecs[3] = '{pat: 0, pool: 1'b1, k: 3,  exp: 72'h0b0c0d_151617_1f2021};
    vecs[4] = '{pat: 0, pool: 1'b1, k: 4,  exp: 72'h020304_0c0d0e_161718};
    vecs[5] = '{pat: 0, pool: 1'b0, k: 1,  exp: 72'h010203_0b0c0d_151617};
    vecs[6] = '{pat: 0, pool: 1'b0, k: 8,  exp: 72'h0a0b0c_141516_1e1f20};
    vecs[7] = '{pat: 0, pool: 1'b0, k: 63, exp: 72'h4d4e4f_575859_616263};
`endif

    pix_valid = 1'b1;
    pix_in = 8'hee;
    @(posedge clk); #1;
    check("rst_ready", WW'(pix_ready), WW'(0));
    check("rst_win", win, '0);
    check("rst_win_en", WW'(win_en), WW'(0));
    check("rst_done", WW'(frame_done), WW'(0));
    check("rst_busy", WW'(busy), WW'(0));
    reset = 1'b0;
    tick();
    check("ready_after_rst", WW'(pix_ready), WW'(1));
    pix_valid = 1'b0;

    load_frame(0, 1'b1, 0);  drain(1'b0);  table_check(0, 1'b1);
    load_frame(0, 1'b0, 0);  drain(1'b0);  table_check(0, 1'b0);
    load_frame(0, 1'b1, 50); drain(1'b1);  table_check(0, 1'b1);
    load_frame(1, 1'b0, 30); drain(1'b1);

    load_frame(0, 1'b1, 0);
    g = 0;
    while (n_got < 21 && g < 100) begin tick(); g++; end
    check("reached_win20", WW'(n_got), WW'(21));
    #1 reset = 1'b1;
    #1;
    check("abort_win_en", WW'(win_en), WW'(0));
    check("abort_win", win, '0);
    check("abort_done", WW'(frame_done), WW'(0));
    check("abort_busy", WW'(busy), WW'(0));
    check("abort_ready", WW'(pix_ready), WW'(0));
    exp_q.delete();
    prev_en = 1'b0;
    run = 0;
    tick();
    reset = 1'b0;
    tick();
    check("ready_after_abort", WW'(pix_ready), WW'(1));
    load_frame(0, 1'b1, 0);  drain(1'b0);  table_check(0, 1'b1);

`ifdef WIN_FEED_ZERO_PAD_EN
    load_frame(2, 1'b0, 0);  drain(1'b0);  table_check(2, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
